// File: rtl/ps2_key_ctrl.sv
// ---------------------------------------------------------------------------
// ps2_key_ctrl
//
// Sequences the PS/2 scancode path. Bytes are popped from the PS/2 receiver
// FIFO through its ready / nextdata_n handshake. Make, break (F0) and extended
// (E0) prefixes are parsed. Accepted key presses are presented to the display
// logic.
//
// Handshake: when in IDLE with ready=1, the head byte is latched and
// nextdata_n is pulsed low for one cycle. The byte is parsed in the following
// PARSE cycle. The maximum rate is one byte every two cycles.
//
// Ports
//   clk          system clock
//   clrn         synchronous reset, active-low
//   ready        receiver FIFO non-empty
//   data[7:0]    receiver FIFO head byte
//   overflow     receiver FIFO overflow indication
//   nextdata_n   active-low pop strobe to the receiver (registered)
//   key_value    byte being parsed, presented to the scancode->ASCII ROM
//   ascii_value  combinational ROM result for key_value
//   cur_scan     scancode of the last accepted make
//   cur_ascii    ASCII of the last accepted make
//   key_down     accepted key currently held
//   key_valid    one-cycle pulse per accepted new press
//   press_cnt    count of accepted presses (wraps)
//   ovf_err      sticky overflow flag, cleared only by reset
//
// Optional feature: macro PS2_SHIFT_EN
//   When defined, scancodes 12 and 59 act as shift keys. They are tracked in
//   an internal held flag and are never reported as presses. A press made
//   while shift is held turns a lowercase ASCII result (61..7A) into uppercase.
//   When undefined, 12 and 59 are handled as ordinary keys.
// ---------------------------------------------------------------------------
module ps2_key_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             ready,
  input  logic [7:0]       data,
  input  logic             overflow,
  output logic             nextdata_n,
  output logic [7:0]       key_value,
  input  logic [7:0]       ascii_value,
  output logic [7:0]       cur_scan,
  output logic [7:0]       cur_ascii,
  output logic             key_down,
  output logic             key_valid,
  output logic [CNT_W-1:0] press_cnt,
  output logic             ovf_err
);

  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;

  typedef enum logic {
    IDLE  = 1'b0,
    PARSE = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       byte_q, byte_d;
  logic             brk_q, brk_d;
  logic             nextdata_n_q, nextdata_n_d;
  logic [7:0]       cur_scan_q, cur_scan_d;
  logic [7:0]       cur_ascii_q, cur_ascii_d;
  logic             key_down_q, key_down_d;
  logic             key_valid_q, key_valid_d;
  logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
  logic             ovf_q, ovf_d;

  logic             is_shift;
  logic [7:0]       ascii_eff;

`ifdef PS2_SHIFT_EN
  logic shift_q, shift_d;

  assign is_shift = (byte_q == 8'h12) || (byte_q == 8'h59);

  // Uppercase conversion applies only to lowercase letters.
  always_comb begin
    ascii_eff = ascii_value;
    if (shift_q && (ascii_value >= 8'h61) && (ascii_value <= 8'h7A)) begin
      ascii_eff = ascii_value - 8'h20;
    end
  end
`else
  assign is_shift  = 1'b0;
  assign ascii_eff = ascii_value;
`endif

  // Next-state and output logic.
  // NOTE: every signal written here gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    byte_d       = byte_q;
    brk_d        = brk_q;
    nextdata_n_d = 1'b1;
    cur_scan_d   = cur_scan_q;
    cur_ascii_d  = cur_ascii_q;
    key_down_d   = key_down_q;
    key_valid_d  = 1'b0;
    press_cnt_d  = press_cnt_q;
    ovf_d        = ovf_q | overflow;
`ifdef PS2_SHIFT_EN
    shift_d      = shift_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (ready) begin
          byte_d       = data;
          nextdata_n_d = 1'b0;
          state_d      = PARSE;
        end
      end

      PARSE: begin
        state_d = IDLE;
        if (byte_q == CODE_EXT) begin
          // The extended prefix carries no information for this path.
        end else if (byte_q == CODE_BRK) begin
          brk_d = 1'b1;
        end else if (brk_q) begin
          brk_d = 1'b0;
          if (is_shift) begin
`ifdef PS2_SHIFT_EN
            shift_d = 1'b0;
`endif
          end else if (byte_q == cur_scan_q) begin
            // A release of a key other than the current one is ignored.
            key_down_d = 1'b0;
          end
        end else if (is_shift) begin
`ifdef PS2_SHIFT_EN
          shift_d = 1'b1;
`endif
        end else if (key_down_q && (byte_q == cur_scan_q)) begin
          // Typematic repeat of the held key: not a new press.
        end else begin
          cur_scan_d  = byte_q;
          cur_ascii_d = ascii_eff;
          key_down_d  = 1'b1;
          key_valid_d = 1'b1;
          press_cnt_d = press_cnt_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments only, so every
  // register samples the values from before the edge regardless of order.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_q      <= IDLE;
      byte_q       <= 8'h00;
      brk_q        <= 1'b0;
      nextdata_n_q <= 1'b1;
      cur_scan_q   <= 8'h00;
      cur_ascii_q  <= 8'h00;
      key_down_q   <= 1'b0;
      key_valid_q  <= 1'b0;
      press_cnt_q  <= '0;
      ovf_q        <= 1'b0;
`ifdef PS2_SHIFT_EN
      shift_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      byte_q       <= byte_d;
      brk_q        <= brk_d;
      nextdata_n_q <= nextdata_n_d;
      cur_scan_q   <= cur_scan_d;
      cur_ascii_q  <= cur_ascii_d;
      key_down_q   <= key_down_d;
      key_valid_q  <= key_valid_d;
      press_cnt_q  <= press_cnt_d;
      ovf_q        <= ovf_d;
`ifdef PS2_SHIFT_EN
      shift_q      <= shift_d;
`endif
    end
  end

  assign nextdata_n = nextdata_n_q;
  assign key_value  = byte_q;
  assign cur_scan   = cur_scan_q;
  assign cur_ascii  = cur_ascii_q;
  assign key_down   = key_down_q;
  assign key_valid  = key_valid_q;
  assign press_cnt  = press_cnt_q;
  assign ovf_err    = ovf_q;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ps2_key_ctrl
//
// Self-checking bench for ps2_key_ctrl. The bench models the receiver FIFO
// as a queue that pops on nextdata_n, and the lookup ROM as a small table.
// It also provides a byte-stream reference model that pushes every expected
// press into a scoreboard. A monitor pops that scoreboard on each key_valid
// pulse. Compile with +define+PS2_SHIFT_EN to exercise the shift feature.
// ---------------------------------------------------------------------------
module tb_ps2_key_ctrl;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             clrn;
  logic             ready;
  logic [7:0]       data;
  logic             overflow;
  logic             nextdata_n;
  logic [7:0]       key_value;
  logic [7:0]       ascii_value;
  logic [7:0]       cur_scan;
  logic [7:0]       cur_ascii;
  logic             key_down;
  logic             key_valid;
  logic [CNT_W-1:0] press_cnt;
  logic             ovf_err;

  int checks   = 0;
  int failures = 0;

  ps2_key_ctrl #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .clrn       (clrn),
    .ready      (ready),
    .data       (data),
    .overflow   (overflow),
    .nextdata_n (nextdata_n),
    .key_value  (key_value),
    .ascii_value(ascii_value),
    .cur_scan   (cur_scan),
    .cur_ascii  (cur_ascii),
    .key_down   (key_down),
    .key_valid  (key_valid),
    .press_cnt  (press_cnt),
    .ovf_err    (ovf_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- lookup ROM ----------------
  function automatic logic [7:0] rom(input logic [7:0] code);
    case (code)
      8'h1C:   rom = 8'h61;
      8'h32:   rom = 8'h62;
      8'h21:   rom = 8'h63;
      8'h23:   rom = 8'h64;
      8'h24:   rom = 8'h65;
      8'h16:   rom = 8'h30;
      8'h1E:   rom = 8'h32;
      8'h29:   rom = 8'h20;
      8'h5A:   rom = 8'h0D;
      default: rom = 8'h00;
    endcase
  endfunction

  always_comb ascii_value = rom(key_value);

  // ---------------- receiver FIFO ----------------
  logic [7:0] fifo_q[$];
  int         pops = 0;

  task automatic refresh();
    ready = (fifo_q.size() != 0);
    data  = ready ? fifo_q[0] : 8'h00;
  endtask

  always @(posedge clk) begin
    if (!nextdata_n && fifo_q.size() != 0) begin
      void'(fifo_q.pop_front());
      pops++;
      refresh();
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [7:0]       scan;
    logic [7:0]       ascii;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t             exp_q[$];
  logic [7:0]       m_scan, m_ascii;
  logic             m_down, m_brk, m_shift;
  logic [CNT_W-1:0] m_cnt;

  function automatic void model_reset();
    m_scan = 8'h00; m_ascii = 8'h00; m_down = 1'b0;
    m_brk = 1'b0; m_shift = 1'b0; m_cnt = '0;
    exp_q.delete();
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    logic shift_code;
    logic [7:0] a;
    exp_t e;
`ifdef PS2_SHIFT_EN
    shift_code = (b == 8'h12) || (b == 8'h59);
`else
    shift_code = 1'b0;
`endif
    if (b == 8'hE0) return;
    if (b == 8'hF0) begin m_brk = 1'b1; return; end
    if (m_brk) begin
      m_brk = 1'b0;
      if (shift_code) m_shift = 1'b0;
      else if (b == m_scan) m_down = 1'b0;
      return;
    end
    if (shift_code) begin m_shift = 1'b1; return; end
    if (m_down && b == m_scan) return;
    a = rom(b);
    if (m_shift && a >= 8'h61 && a <= 8'h7A) a = a - 8'h20;
    m_scan = b; m_ascii = a; m_down = 1'b1;
    m_cnt  = CNT_W'((int'(m_cnt) + 1) % (1 << CNT_W));
    e.scan = b; e.ascii = a; e.cnt = m_cnt;
    exp_q.push_back(e);
  endfunction

  // ---------------- monitor ----------------
  int kv_pulses = 0;
  int nd_pulses = 0;
  int nd_run    = 0;

  always @(negedge clk) begin
    if (clrn && key_valid) begin
      kv_pulses++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL kv_spurious: key_valid with scan %0h and no press expected", cur_scan);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("mon_scan",  cur_scan,  e.scan);
        check("mon_ascii", cur_ascii, e.ascii);
        check("mon_cnt",   press_cnt, e.cnt);
        check("mon_down",  key_down,  1'b1);
      end
    end
    if (!nextdata_n) begin
      if (nd_run == 0) nd_pulses++;
      nd_run++;
    end else if (nd_run != 0) begin
      check("nd_width", nd_run, 1);
      nd_run = 0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    fifo_q.push_back(b);
    refresh();
    model_byte(b);
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (fifo_q.size() == 0 && nextdata_n) break;
    end
    if (i == 4000) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: fifo %0d bytes left", fifo_q.size());
    end
    repeat (3) @(negedge clk);
    check("drain_pending", exp_q.size(), 0);
  endtask

  task automatic check_model();
    check("st_scan",  cur_scan,  m_scan);
    check("st_ascii", cur_ascii, m_ascii);
    check("st_cnt",   press_cnt, m_cnt);
    check("st_down",  key_down,  m_down);
  endtask

  task automatic check_reset_outputs();
    check("rst_nd",    nextdata_n, 1'b1);
    check("rst_scan",  cur_scan,   8'h00);
    check("rst_ascii", cur_ascii,  8'h00);
    check("rst_down",  key_down,   1'b0);
    check("rst_valid", key_valid,  1'b0);
    check("rst_cnt",   press_cnt,  '0);
    check("rst_ovf",   ovf_err,    1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    clrn = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    model_reset();
    clrn = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [7:0] pool [10];
    clrn = 1'b0;
    overflow = 1'b0;
    refresh();
    model_reset();
    pool = '{8'h1C, 8'h32, 8'h16, 8'h21, 8'h12, 8'h59, 8'hE0, 8'hF0, 8'h5A, 8'h77};

    // Basic press and release
    do_reset();
    nd_pulses = 0;
    kv_pulses = 0;
    send(8'h1C); send(8'hF0); send(8'h1C);
    drain();
    check("t1_scan",   cur_scan,  8'h1C);
    check("t1_ascii",  cur_ascii, 8'h61);
    check("t1_cnt",    press_cnt, 8'd1);
    check("t1_down",   key_down,  1'b0);
    check("t1_kv",     kv_pulses, 1);
    check("t1_pulses", nd_pulses, 3);

    // Typematic repeat
    do_reset();
    repeat (4) send(8'h1C);
    send(8'hF0); send(8'h1C);
    drain();
    check("t2_cnt",  press_cnt, 8'd1);
    check("t2_down", key_down,  1'b0);

    // Replacement and break of a non-current key
    do_reset();
    send(8'h1C); send(8'h32); send(8'hF0); send(8'h1C);
    drain();
    check("t3_scan",  cur_scan,  8'h32);
    check("t3_ascii", cur_ascii, 8'h62);
    check("t3_cnt",   press_cnt, 8'd2);
    check("t3_down",  key_down,  1'b1);

    // Counter wrap and sticky overflow
    do_reset();
    for (int i = 0; i < 255; i++) begin
      send(8'h1C); send(8'hF0); send(8'h1C);
    end
    drain();
    check("t4_cnt_ff", press_cnt, 8'hFF);
    check("t4_ovf0",   ovf_err,   1'b0);
    send(8'h1C);
    drain();
    check("t4_cnt_wrap", press_cnt, 8'h00);
    @(negedge clk); overflow = 1'b1;
    @(negedge clk); overflow = 1'b0;
    check("t4_ovf_set", ovf_err, 1'b1);
    repeat (20) @(negedge clk);
    check("t4_ovf_hold", ovf_err, 1'b1);
    send(8'h32);
    drain();
    check_model();

    // Reset while nextdata_n is low: the latched byte is discarded
    @(negedge clk);
    fifo_q.push_back(8'h21);
    refresh();
    begin
      int i;
      for (i = 0; i < 50; i++) begin
        @(negedge clk);
        if (!nextdata_n) break;
      end
      if (i == 50) begin
        checks++;
        failures++;
        $display("FAIL t5_no_pop: nextdata_n never went low");
      end
    end
    clrn = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    check("t5_fifo_empty", fifo_q.size(), 0);
    model_reset();
    clrn = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_no_pop_after", nextdata_n, 1'b1);
    send(8'h16);
    drain();
    check("t5_ascii", cur_ascii, 8'h30);
    check("t5_cnt",   press_cnt, 8'd1);

    // Shift sequence
    do_reset();
    send(8'h12); send(8'h1C); send(8'hF0); send(8'h1C);
    send(8'hF0); send(8'h12); send(8'h1C);
    drain();
    check("t6_ascii", cur_ascii, 8'h61);
`ifdef PS2_SHIFT_EN
    check("t6_cnt", press_cnt, 8'd2);
`else
    check("t6_cnt", press_cnt, 8'd3);
`endif
    check_model();

    // Randomized byte stream with random gaps
    do_reset();
    for (int i = 0; i < 400; i++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel == 9) send(8'($urandom_range(0, 255)));
      else send(pool[sel]);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();
    check_model();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
